// File: rtl/cnn_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pixel_streamer
//  Description : Captures one IMG_W x IMG_H frame through a write port into an
//                internal buffer, then streams it in raster order over a
//                valid/ready interface with SOF/EOL/EOF markers and a done
//                pulse after the final transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_pixel_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  frame_full,
    input  logic                  start,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  done
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_LOAD   = 2'd1;
    localparam logic [1:0] c_S_FULL   = 2'd2;
    localparam logic [1:0] c_S_STREAM = 2'd3;

    localparam int c_NPIX  = IMG_W * IMG_H;
    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);

    localparam logic [ADDR_W-1:0]  c_WR_LAST  = ADDR_W'(c_NPIX - 1);
    localparam logic [ADDR_W:0]    c_RD_END   = (ADDR_W + 1)'(c_NPIX);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [ADDR_W-1:0]     r_wr_ptr;
    // One extra bit so the read pointer can reach N when N == 2**ADDR_W.
    logic [ADDR_W:0]       r_rd_ptr;
    logic [c_COL_W-1:0]    r_col;
    logic [c_ROW_W-1:0]    r_row;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_sof;
    logic                  r_eol;
    logic                  r_eof;
    logic                  r_done;

    logic w_wr;
    logic w_wr_last;
    logic w_start;
    logic w_xfer;
    logic w_load;
    logic w_last_xfer;

    assign w_wr        = wr_en && ((r_state == c_S_IDLE) || (r_state == c_S_LOAD));
    assign w_wr_last   = w_wr && (r_state == c_S_LOAD) && (r_wr_ptr == c_WR_LAST);
    assign w_start     = start && (r_state == c_S_FULL);
    assign w_xfer      = r_out_valid && out_ready;
    assign w_last_xfer = (r_state == c_S_STREAM) && w_xfer && r_eof;
    // Pixel 0 is loaded on the start edge itself so out_valid rises one cycle
    // after start; later pixels load whenever the output slot is free.
    assign w_load      = w_start ||
                         ((r_state == c_S_STREAM) && (!r_out_valid || out_ready) &&
                          (r_rd_ptr < c_RD_END));

    // State register
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (wr_en)       w_state_nxt = c_S_LOAD;
            c_S_LOAD:   if (w_wr_last)   w_state_nxt = c_S_FULL;
            c_S_FULL:   if (start)       w_state_nxt = c_S_STREAM;
            c_S_STREAM: if (w_last_xfer) w_state_nxt = c_S_IDLE;
            default:                     w_state_nxt = c_S_IDLE;
        endcase
    end

    // Frame buffer write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Write pointer, wrapping to 0 once the last pixel of the frame lands
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_wr_ptr <= '0;
        end else if (w_wr) begin
            r_wr_ptr <= (r_wr_ptr == c_WR_LAST) ? '0 : r_wr_ptr + 1'b1;
        end
    end

    // Read pointer, column/row counters and the output register
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_rd_ptr    <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_last_xfer;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_mem[r_rd_ptr[ADDR_W-1:0]];
                r_sof       <= (r_rd_ptr == '0);
                r_eol       <= (r_col == c_COL_LAST);
                r_eof       <= (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else begin
                if (w_xfer) begin
                    r_out_valid <= 1'b0;
                    r_sof       <= 1'b0;
                    r_eol       <= 1'b0;
                    r_eof       <= 1'b0;
                end
                // Park the read side at pixel 0 outside streaming so the
                // next start always begins a fresh raster.
                if (r_state != c_S_STREAM) begin
                    r_rd_ptr <= '0;
                    r_col    <= '0;
                    r_row    <= '0;
                end
            end
        end
    end

    assign wr_ready   = (r_state == c_S_IDLE) || (r_state == c_S_LOAD);
    assign frame_full = (r_state == c_S_FULL);
    assign busy       = (r_state == c_S_STREAM);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_sof    = r_sof;
    assign out_eol    = r_eol;
    assign out_eof    = r_eof;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: doc/cnn_pixel_streamer.md
Name: cnn_pixel_streamer

Overview:
- Transmit-side feeder for the CNN classifier's pixel input.
- Captures one image frame (IMG_W x IMG_H pixels, DATA_WIDTH each) over a simple write port into an internal buffer.
- On a start request, streams the frame out in raster order over a valid/ready interface, with start-of-frame, end-of-line and end-of-frame markers.
- Pulses done when the last pixel is accepted.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_W, 8, pixels per row (>=2).
- IMG_H, 8, rows per frame (>=2).
- ADDR_W, 6, buffer address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_  in  1  synchronous, active-high reset (asserted = 1, sampled on rising clk).
- wr_en  in  1  write strobe for one pixel; honoured only while wr_ready=1.
- wr_data  in  DATA_WIDTH  pixel to store.
- wr_ready  out  1  buffer accepting pixels (state IDLE or LOAD).
- frame_full  out  1  full frame captured, awaiting start (state FULL).
- start  in  1  begin streaming; honoured only in FULL.
- busy  out  1  state STREAM.
- out_valid  out  1  out_data holds a valid pixel.
- out_ready  in  1  downstream accepts the pixel this cycle.
- out_data  out  DATA_WIDTH  streamed pixel.
- out_sof  out  1  qualifies out_data as pixel 0.
- out_eol  out  1  qualifies out_data as the last pixel of a row.
- out_eof  out  1  qualifies out_data as the last pixel of the frame.
- done  out  1  one-cycle pulse after the last pixel transfer.

Behaviour:
- N = IMG_W*IMG_H. A transfer occurs on a cycle with out_valid=1 and out_ready=1.

Reset (rst_=1 at a clock edge):
- State=IDLE, wr_ptr=0, rd_ptr=0.
- Outputs: wr_ready=1; frame_full, busy, out_valid, out_sof, out_eol, out_eof, done=0; out_data=0.
- Buffer contents are not cleared.
- Reset in any state, including mid-stream, aborts immediately; any partial frame is discarded.

States:
- IDLE: wr_en stores wr_data at address 0, wr_ptr=1, next state LOAD.
- LOAD: each wr_en stores at wr_ptr and increments it. The write of pixel N-1 moves to FULL, with wr_ptr wrapped to 0. start is ignored.
- FULL: wr_en is ignored (wr_ready=0). start moves to STREAM, with rd_ptr=0.
- STREAM: the output register loads mem[rd_ptr] when out_valid=0 or a transfer occurs, provided rd_ptr<N; rd_ptr then increments.
  - First pixel: out_valid rises on the cycle after the start cycle (latency 1).
  - Sustained throughput: 1 pixel/cycle when out_ready is held high.
  - After the final transfer (pixel N-1 with out_eof=1): out_valid=0, done=1 for exactly one cycle, state returns to IDLE.
- The frame must be reloaded before it can be streamed again.

Output register and marker rules:
- While out_valid=1 and out_ready=0, out_data, out_sof, out_eol and out_eof hold stable; no pixel is dropped or duplicated.
- out_sof=1 for pixel 0 only.
- out_eol=1 for pixel index k with (k mod IMG_W)=IMG_W-1.
- out_eof=1 for pixel N-1; out_eol is also 1 on that pixel.
- All markers are 0 whenever out_valid=0.
- Markers are generated from a column counter (0..IMG_W-1, wrapping) and a row counter. No divider is used.

Simultaneous and boundary events:
- start in any state other than FULL: ignored, no side effect.
- wr_en and start in the same cycle in LOAD: the write is taken, start is ignored.
- out_ready=1 while out_valid=0: no effect.
- out_ready toggling every cycle: each pixel is transferred exactly once, in order.
- wr_en outside IDLE/LOAD: dropped; the pointer is unchanged.

Test Plan:
1. Reset, write pixels 0..63 (value=index) on consecutive cycles with IMG_W=IMG_H=8 -> wr_ready=1 throughout writes; frame_full=1 on the cycle after the 64th write; wr_ready=0.
2. From FULL, pulse start with out_ready=1 -> out_valid rises the next cycle; out_data=0..63 on 64 consecutive cycles; out_sof only on 0; out_eol on 7,15,...,63; out_eof only on 63; done=1 one cycle later; back in IDLE.
3. Stream with out_ready pattern 1,0,0,1 repeating -> out_data is held stable during stalls; all 64 values are received once, in order; done only after value 63 is transferred.
4. Pulse start in IDLE and after 10 writes in LOAD; assert wr_en in FULL with data 0xFF -> no streaming occurs; frame_full only after 64 accepted writes; streamed data contains no 0xFF.
5. Assert rst_ for one cycle after 20 pixels are transferred -> the next cycle shows out_valid=0, busy=0, done=0, wr_ready=1; a new 64-pixel load and stream completes normally.
